hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage core. It watches the ID stage's source registers, the instruction held in the ID/EX register, and the MEM-stage memory handshake. From these it drives the stall, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stages. It also sequences multi-cycle EX operations (mul/div) with an internal countdown, and flags memory accesses that never complete.

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use, taken-branch flush, mul/div sequencing and MEM watchdog.
// Outputs are combinational (same-cycle effect); a stalled memory handshake overrides every other request.
module hazard_ctrl #(
    parameter int MC_CYCLES   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_read_addr1_i,
    input  logic [4:0] id_read_addr2_i,
    input  logic       id_uses_reg1_i,
    input  logic       id_uses_reg2_i,
    input  logic [4:0] ex_reg_write_addr_i,
    input  logic       ex_mem_read_ctrl_i,
    input  logic       ex_multicycle_i,
    input  logic       branch_taken_i,
    input  logic       mem_req_i,
    input  logic       mem_ready_i,
    output logic       pc_stall_o,
    output logic       if_id_stall_o,
    output logic       if_id_flush_o,
    output logic       id_ex_stall_o,
    output logic       id_ex_bubble_o,
    output logic       ex_mem_stall_o,
    output logic       ex_mem_bubble_o,
    output logic       mem_wb_bubble_o,
    output logic       mc_start_o,
    output logic       mc_busy_o,
    output logic       mem_timeout_o
);

    localparam int MCW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MCW-1:0] MC_LOAD  = MCW'(MC_CYCLES - 2);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_TRIP = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic mem_wait;
    logic load_use;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_bubble_c;
    logic ex_mem_stall_c, ex_mem_bubble_c, mem_wb_bubble_c, mc_start_c;

    assign mem_wait = mem_req_i & ~mem_ready_i;
    assign load_use = ex_mem_read_ctrl_i & (ex_reg_write_addr_i != 5'd0) &
                      ((id_uses_reg1_i & (id_read_addr1_i == ex_reg_write_addr_i)) |
                       (id_uses_reg2_i & (id_read_addr2_i == ex_reg_write_addr_i)));

    always_comb begin
        state_d         = state_q;
        mc_cnt_d        = mc_cnt_q;
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_stall_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        ex_mem_stall_c  = 1'b0;
        ex_mem_bubble_c = 1'b0;
        mem_wb_bubble_c = 1'b0;
        mc_start_c      = 1'b0;

        // The mul/div countdown keeps running even while MEM holds the pipe.
        if (state_q == MC_BUSY && mc_cnt_q != '0) begin
            mc_cnt_d = mc_cnt_q - 1'b1;
        end

        if (mem_wait) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_stall_c   = 1'b1;
            ex_mem_stall_c  = 1'b1;
            mem_wb_bubble_c = 1'b1;
        end else if (state_q == RUN && ex_multicycle_i) begin
            mc_start_c      = 1'b1;
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_stall_c   = 1'b1;
            ex_mem_bubble_c = 1'b1;
            state_d         = MC_BUSY;
            mc_cnt_d        = MC_LOAD;
        end else if (state_q == MC_BUSY && mc_cnt_q != '0) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            id_ex_stall_c   = 1'b1;
            ex_mem_bubble_c = 1'b1;
        end else if (state_q == MC_BUSY) begin
            state_d = RUN;
        end else if (load_use) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_c = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        // Flag shows during the cycle that completes the tolerated wait count.
        timeout_d = timeout_q | (mem_wait & (wait_cnt_q >= WAIT_TRIP));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            mc_cnt_q   <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mc_cnt_q   <= mc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pc_stall_o      = ~rst_i & pc_stall_c;
    assign if_id_stall_o   = ~rst_i & if_id_stall_c;
    assign if_id_flush_o   = ~rst_i & if_id_flush_c;
    assign id_ex_stall_o   = ~rst_i & id_ex_stall_c;
    assign id_ex_bubble_o  = ~rst_i & id_ex_bubble_c;
    assign ex_mem_stall_o  = ~rst_i & ex_mem_stall_c;
    assign ex_mem_bubble_o = ~rst_i & ex_mem_bubble_c;
    assign mem_wb_bubble_o = ~rst_i & mem_wb_bubble_c;
    assign mc_start_o      = ~rst_i & mc_start_c;
    assign mc_busy_o       = ~rst_i & (state_q == MC_BUSY);
    assign mem_timeout_o   = ~rst_i & timeout_d;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios against hand-derived vectors, then random traffic against a cycle model.
module tb_hazard_ctrl;

    localparam int MC  = 8;
    localparam int TMO = 4;

    // Output vector bit masks: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
    //                            ex_mem_stall, ex_mem_bubble, mem_wb_bubble, mc_start, mc_busy, mem_timeout}
    localparam logic [10:0] B_PC  = 11'h400;
    localparam logic [10:0] B_IFS = 11'h200;
    localparam logic [10:0] B_IFF = 11'h100;
    localparam logic [10:0] B_IDS = 11'h080;
    localparam logic [10:0] B_IDB = 11'h040;
    localparam logic [10:0] B_EMS = 11'h020;
    localparam logic [10:0] B_EMB = 11'h010;
    localparam logic [10:0] B_MWB = 11'h008;
    localparam logic [10:0] B_MCS = 11'h004;
    localparam logic [10:0] B_MCB = 11'h002;
    localparam logic [10:0] B_TO  = 11'h001;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_read_addr1_i, id_read_addr2_i, ex_reg_write_addr_i;
    logic       id_uses_reg1_i, id_uses_reg2_i, ex_mem_read_ctrl_i, ex_multicycle_i;
    logic       branch_taken_i, mem_req_i, mem_ready_i;
    logic       pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o;
    logic       ex_mem_stall_o, ex_mem_bubble_o, mem_wb_bubble_o, mc_start_o, mc_busy_o, mem_timeout_o;

    hazard_ctrl #(.MC_CYCLES(MC), .MEM_TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_read_addr1_i(id_read_addr1_i), .id_read_addr2_i(id_read_addr2_i),
        .id_uses_reg1_i(id_uses_reg1_i), .id_uses_reg2_i(id_uses_reg2_i),
        .ex_reg_write_addr_i(ex_reg_write_addr_i), .ex_mem_read_ctrl_i(ex_mem_read_ctrl_i),
        .ex_multicycle_i(ex_multicycle_i), .branch_taken_i(branch_taken_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_stall_o(id_ex_stall_o), .id_ex_bubble_o(id_ex_bubble_o),
        .ex_mem_stall_o(ex_mem_stall_o), .ex_mem_bubble_o(ex_mem_bubble_o),
        .mem_wb_bubble_o(mem_wb_bubble_o), .mc_start_o(mc_start_o), .mc_busy_o(mc_busy_o),
        .mem_timeout_o(mem_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    wire [10:0] obs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_bubble_o,
                       ex_mem_stall_o, ex_mem_bubble_o, mem_wb_bubble_o, mc_start_o, mc_busy_o,
                       mem_timeout_o};

    int checks = 0;
    int errors = 0;

    // Reference model: ex_age counts EX cycles already spent by a multi-cycle op (0 = not busy).
    int ex_age;
    int waits;
    bit to_flag;

    function automatic bit m_wait();
        return mem_req_i && !mem_ready_i;
    endfunction

    function automatic logic [10:0] model_out();
        logic [10:0] e;
        bit busy, lu;
        e = '0;
        if (rst_i) return e;
        busy = (ex_age > 0);
        lu = ex_mem_read_ctrl_i && (ex_reg_write_addr_i != 0) &&
             ((id_uses_reg1_i && id_read_addr1_i == ex_reg_write_addr_i) ||
              (id_uses_reg2_i && id_read_addr2_i == ex_reg_write_addr_i));
        if (m_wait())
            e = B_PC | B_IFS | B_IDS | B_EMS | B_MWB;
        else if (!busy && ex_multicycle_i)
            e = B_MCS | B_PC | B_IFS | B_IDS | B_EMB;
        else if (busy && ex_age < MC - 1)
            e = B_PC | B_IFS | B_IDS | B_EMB;
        else if (busy)
            e = '0;
        else if (lu)
            e = B_PC | B_IFS | B_IDB;
        else if (branch_taken_i)
            e = B_IFF;
        if (busy) e = e | B_MCB;
        if (to_flag || (m_wait() && waits + 1 >= TMO)) e = e | B_TO;
        return e;
    endfunction

    task automatic model_step();
        if (ex_age > 0) begin
            if (ex_age >= MC - 1 && !m_wait()) ex_age = 0;
            else ex_age = ex_age + 1;
        end else if (ex_multicycle_i && !m_wait()) begin
            ex_age = 1;
        end
        waits = m_wait() ? waits + 1 : 0;
        if (waits >= TMO) to_flag = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) begin
            ex_age = 0; waits = 0; to_flag = 1'b0;
        end else begin
            model_step();
        end
        #1;
    endtask

    task automatic set_idle();
        id_read_addr1_i = 5'd0; id_read_addr2_i = 5'd0; ex_reg_write_addr_i = 5'd0;
        id_uses_reg1_i = 1'b0; id_uses_reg2_i = 1'b0; ex_mem_read_ctrl_i = 1'b0;
        ex_multicycle_i = 1'b0; branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        ex_multicycle_i = 1'b1; branch_taken_i = 1'b1; mem_req_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (obs !== 11'h000) begin
            errors++; $display("FAIL reset_held: got %b want %b", obs, 11'h000);
        end
        tick();
        set_idle();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (obs !== 11'h000) begin
            errors++; $display("FAIL reset_idle: got %b want %b", obs, 11'h000);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [10:0] want [6];
        want = '{B_PC | B_IFS | B_IDB, 11'h000, 11'h000, B_PC | B_IFS | B_IDB, 11'h000, 11'h000};
        for (int i = 0; i < 6; i++) begin
            set_idle();
            case (i)
                0: begin ex_mem_read_ctrl_i = 1; ex_reg_write_addr_i = 5; id_read_addr1_i = 5; id_uses_reg1_i = 1; end
                1: begin id_read_addr1_i = 5; id_uses_reg1_i = 1; ex_reg_write_addr_i = 0; end
                2: begin ex_mem_read_ctrl_i = 1; ex_reg_write_addr_i = 0; id_read_addr1_i = 0; id_uses_reg1_i = 1; end
                3: begin ex_mem_read_ctrl_i = 1; ex_reg_write_addr_i = 7; id_read_addr2_i = 7; id_uses_reg2_i = 1; end
                4: begin ex_mem_read_ctrl_i = 1; ex_reg_write_addr_i = 7; id_read_addr2_i = 7; id_uses_reg2_i = 0; end
                default: begin ex_mem_read_ctrl_i = 0; ex_reg_write_addr_i = 7; id_read_addr1_i = 7; id_uses_reg1_i = 1; end
            endcase
            @(negedge clk_i);
            checks++;
            if (obs !== want[i]) begin
                errors++; $display("FAIL load_use step %0d: got %b want %b", i, obs, want[i]);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_branch();
        logic [10:0] want [3];
        want = '{B_IFF, B_PC | B_IFS | B_IDB, 11'h000};
        for (int i = 0; i < 3; i++) begin
            set_idle();
            if (i == 0) branch_taken_i = 1;
            if (i == 1) begin
                branch_taken_i = 1; ex_mem_read_ctrl_i = 1; ex_reg_write_addr_i = 3;
                id_read_addr1_i = 3; id_uses_reg1_i = 1;
            end
            @(negedge clk_i);
            checks++;
            if (obs !== want[i]) begin
                errors++; $display("FAIL branch step %0d: got %b want %b", i, obs, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_multicycle();
        logic [10:0] want;
        set_idle();
        ex_multicycle_i = 1'b1;
        for (int c = 0; c < MC + 1; c++) begin
            if (c == MC) set_idle();
            if (c == 0) want = B_MCS | B_PC | B_IFS | B_IDS | B_EMB;
            else if (c < MC - 1) want = B_MCB | B_PC | B_IFS | B_IDS | B_EMB;
            else if (c == MC - 1) want = B_MCB;
            else want = 11'h000;
            @(negedge clk_i);
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL multicycle ex_cycle %0d: got %b want %b", c + 1, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_mem_wait_busy();
        logic [10:0] want;
        set_idle();
        ex_multicycle_i = 1'b1;
        tick();
        repeat (MC - 3) tick();
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) mem_ready_i = 1'b1;
            if (c == 4) set_idle();
            if (c < 3) want = B_PC | B_IFS | B_IDS | B_EMS | B_MWB | B_MCB;
            else if (c == 3) want = B_MCB;
            else want = 11'h000;
            @(negedge clk_i);
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL mem_wait_busy step %0d: got %b want %b", c, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [10:0] want;
        set_idle();
        mem_req_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) mem_ready_i = 1'b1;
            if (c == 5) set_idle();
            if (c < 3) want = B_PC | B_IFS | B_IDS | B_EMS | B_MWB;
            else if (c == 3) want = B_PC | B_IFS | B_IDS | B_EMS | B_MWB | B_TO;
            else want = B_TO;
            @(negedge clk_i);
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL timeout step %0d: got %b want %b", c, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        ex_multicycle_i = 1'b1;
        tick();
        repeat (3) tick();
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin set_idle(); rst_i = 1'b0; end
            @(negedge clk_i);
            checks++;
            if (obs !== 11'h000) begin
                errors++; $display("FAIL reset_mid step %0d: got %b want %b", c, obs, 11'h000);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [10:0] want;
        for (int c = 0; c < 600; c++) begin
            rst_i               = ($urandom_range(99) < 2);
            id_read_addr1_i     = 5'($urandom_range(3));
            id_read_addr2_i     = 5'($urandom_range(3));
            ex_reg_write_addr_i = 5'($urandom_range(3));
            id_uses_reg1_i      = 1'($urandom_range(1));
            id_uses_reg2_i      = 1'($urandom_range(1));
            ex_mem_read_ctrl_i  = ($urandom_range(99) < 40);
            ex_multicycle_i     = ($urandom_range(99) < 12);
            branch_taken_i      = ($urandom_range(99) < 25);
            mem_req_i           = ($urandom_range(99) < 45);
            mem_ready_i         = ($urandom_range(99) < 40);
            want = model_out();
            @(negedge clk_i);
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL random cycle %0d: got %b want %b", c, obs, want);
            end
            tick();
        end
        rst_i = 1'b0;
        set_idle();
    endtask

    initial begin
        rst_i = 1'b1;
        ex_age = 0; waits = 0; to_flag = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle();
        test_mem_wait_busy();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
